// File: rtl/module_pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline register sequencer.
// Combinational/zero-latency controls; no handshake, no backpressure of its own.
// Contents: FSM state enum, packed stall/flush bundle, defaults, counter width helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } ctrl_state_t;

  // Per-stage register controls; the datapath top reuses this bundle.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic stall_e;
    logic flush_e;
    logic stall_m;
    logic flush_w;
  } pipe_ctrl_t;

  localparam int unsigned BOOT_CYCLES_DEF = 4;
  localparam int unsigned TIMEOUT_DEF     = 64;

  // Boot: hold PC and clear every downstream register.
  localparam pipe_ctrl_t CTRL_BOOT = '{
    stall_f: 1'b1, stall_d: 1'b0, flush_d: 1'b1, stall_e: 1'b0,
    flush_e: 1'b1, stall_m: 1'b0, flush_w: 1'b1
  };

  // Memory freeze: hold everything up to EX/MEM, bubble into Writeback.
  localparam pipe_ctrl_t CTRL_FREEZE = '{
    stall_f: 1'b1, stall_d: 1'b1, flush_d: 1'b0, stall_e: 1'b1,
    flush_e: 1'b0, stall_m: 1'b1, flush_w: 1'b1
  };

  // Shared counter must reach the larger of the two terminal counts.
  function automatic int cnt_width(input int unsigned boot_cycles,
                                   input int unsigned timeout);
    int unsigned m;
    m = (boot_cycles > timeout) ? boot_cycles : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/module_pipeline_ctrl_if.sv
// Bundle of hazard inputs and stall/flush outputs between datapath and sequencer.
// Zero latency: pure wires; no backpressure.
// Ports: master = datapath (drives hazard info, consumes controls); slave = sequencer.
interface module_pipeline_ctrl_if #(
  parameter int unsigned REG_W = 5
);

  logic [REG_W-1:0] rs1_d_i;
  logic [REG_W-1:0] rs2_d_i;
  logic [REG_W-1:0] rd_e_i;
  logic             load_e_i;
  logic             pc_src_e_i;
  logic             dmem_req_m_i;
  logic             dmem_ack_i;

  logic             stall_f_o;
  logic             stall_d_o;
  logic             flush_d_o;
  logic             stall_e_o;
  logic             flush_e_o;
  logic             stall_m_o;
  logic             flush_w_o;
  logic             boot_o;
  logic             fault_o;

  modport master (
    output rs1_d_i, rs2_d_i, rd_e_i, load_e_i, pc_src_e_i, dmem_req_m_i, dmem_ack_i,
    input  stall_f_o, stall_d_o, flush_d_o, stall_e_o, flush_e_o, stall_m_o,
           flush_w_o, boot_o, fault_o
  );

  modport slave (
    input  rs1_d_i, rs2_d_i, rd_e_i, load_e_i, pc_src_e_i, dmem_req_m_i, dmem_ack_i,
    output stall_f_o, stall_d_o, flush_d_o, stall_e_o, flush_e_o, stall_m_o,
           flush_w_o, boot_o, fault_o
  );

endinterface

// File: rtl/module_pipeline_ctrl_hazard.sv
// Load-use and taken-branch controls for the pipeline when memory is not frozen.
// Purely combinational, zero latency; no backpressure.
// Ports: rs1_d/rs2_d/rd_e register indices, load_e, pc_src_e in; run_ctrl bundle out.
module module_hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             load_e,
  input  logic             pc_src_e,
  output pipe_ctrl_t       run_ctrl
);

  logic lwstall;

  // x0 never carries a real result, so a load into it creates no hazard.
  assign lwstall = load_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

  always_comb begin
    run_ctrl         = '0;
    run_ctrl.stall_f = lwstall;
    // stall_d stays high alongside flush_d on a branch; the register gives clear priority.
    run_ctrl.stall_d = lwstall;
    run_ctrl.flush_d = pc_src_e;
    run_ctrl.flush_e = lwstall | pc_src_e;
  end

endmodule

// File: rtl/module_pipeline_ctrl.sv
// Sequencer for IF/ID, ID/EX, EX/MEM, MEM/WB: boot flush, hazards, dmem wait, timeout.
// Outputs combinational from state/counter/inputs: zero latency.
// Backpressure: dmem request without ack freezes the pipe; TIMEOUT waits -> sticky fault.
// Ports: clk_i, rst_ni (async active-low), bus (slave modport of module_pipeline_ctrl_if).
module module_pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = BOOT_CYCLES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned REG_W       = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  module_pipeline_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(BOOT_CYCLES, TIMEOUT);
  localparam logic [CNT_W-1:0] BOOT_LAST    = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pipe_ctrl_t       run_ctrl;
  pipe_ctrl_t       ctrl;
  logic             boot;
  logic             fault;
  logic             freeze;

  module_hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .rs1_d    (bus.rs1_d_i),
    .rs2_d    (bus.rs2_d_i),
    .rd_e     (bus.rd_e_i),
    .load_e   (bus.load_e_i),
    .pc_src_e (bus.pc_src_e_i),
    .run_ctrl (run_ctrl)
  );

  assign freeze = bus.dmem_req_m_i & ~bus.dmem_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;
    boot    = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      BOOT: begin
        ctrl = CTRL_BOOT;
        boot = 1'b1;
        if (cnt_q == BOOT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (freeze) begin
          // Branch/load-use actions wait: Execute is held and re-evaluates later.
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          ctrl = run_ctrl;
        end
      end
      MEM_WAIT: begin
        // The request itself is held in the frozen EX/MEM register; only ack matters.
        if (bus.dmem_ack_i) begin
          ctrl    = run_ctrl;
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          ctrl = CTRL_FREEZE;
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = FAULT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FAULT: begin
        ctrl  = CTRL_FREEZE;
        fault = 1'b1;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  assign bus.stall_f_o = ctrl.stall_f;
  assign bus.stall_d_o = ctrl.stall_d;
  assign bus.flush_d_o = ctrl.flush_d;
  assign bus.stall_e_o = ctrl.stall_e;
  assign bus.flush_e_o = ctrl.flush_e;
  assign bus.stall_m_o = ctrl.stall_m;
  assign bus.flush_w_o = ctrl.flush_w;
  assign bus.boot_o    = boot;
  assign bus.fault_o   = fault;

endmodule

// File: tb/tb_module_pipeline_ctrl.sv
// Scoreboard bench for module_pipeline_ctrl (BOOT_CYCLES=4, TIMEOUT=8).
// Stimulus changes inputs 1 time unit after each rising edge and queues the expected outputs;
// the monitor samples on the falling edge and compares against the queue head.
module tb_module_pipeline_ctrl;

  // Output vector order: stall_f stall_d flush_d stall_e flush_e stall_m flush_w boot fault
  localparam logic [8:0] V_BOOT = 9'b1_0_1_0_1_0_1_1_0;
  localparam logic [8:0] V_ZERO = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_LW   = 9'b1_1_0_0_1_0_0_0_0;
  localparam logic [8:0] V_BR   = 9'b0_0_1_0_1_0_0_0_0;
  localparam logic [8:0] V_LWBR = 9'b1_1_1_0_1_0_0_0_0;
  localparam logic [8:0] V_FRZ  = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] V_FLT  = 9'b1_1_0_1_0_1_1_0_1;

  logic clk;
  logic rst_n;

  module_pipeline_ctrl_if #(.REG_W(5)) bus ();

  module_pipeline_ctrl #(
    .BOOT_CYCLES (4),
    .TIMEOUT     (8),
    .REG_W       (5)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string      name_q[$];
  logic [8:0] exp_q[$];
  int         checks;
  int         errors;

  logic [8:0] got;
  assign got = {bus.stall_f_o, bus.stall_d_o, bus.flush_d_o, bus.stall_e_o, bus.flush_e_o,
                bus.stall_m_o, bus.flush_w_o, bus.boot_o, bus.fault_o};

  // Monitor: compares whenever an expectation is pending for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      string      nm;
      logic [8:0] e;
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, e, $time);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic ld,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic pc, input logic req, input logic ack,
                      input logic [8:0] e);
    @(posedge clk);
    #1;
    rst_n            = r;
    bus.load_e_i     = ld;
    bus.rd_e_i       = rd;
    bus.rs1_d_i      = rs1;
    bus.rs2_d_i      = rs2;
    bus.pc_src_e_i   = pc;
    bus.dmem_req_m_i = req;
    bus.dmem_ack_i   = ack;
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  // Release reset: exactly four boot cycles, then a quiet RUN cycle.
  task automatic boot_seq();
    step("boot_rel", 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, V_BOOT);
    for (int i = 0; i < 3; i++)
      step("boot", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_BOOT);
    step("boot_done", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_ZERO);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.load_e_i     = 1'b0;
    bus.rd_e_i       = '0;
    bus.rs1_d_i      = '0;
    bus.rs2_d_i      = '0;
    bus.pc_src_e_i   = 1'b0;
    bus.dmem_req_m_i = 1'b0;
    bus.dmem_ack_i   = 1'b0;
    name_q.push_back("reset");
    exp_q.push_back(V_BOOT);
    @(negedge clk);
    #1;

    // Hazard inputs are driven during boot and must be ignored.
    boot_seq();

    // Load-use and branch equations in RUN.
    step("lw_rs2",    1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, V_LW);
    step("lw_rd0",    1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_ZERO);
    step("lw_rs1",    1'b1, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, 1'b0, V_LW);
    step("no_load",   1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, V_ZERO);
    step("branch",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, V_BR);
    step("lw_branch", 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, V_LWBR);
    step("req_ack",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, V_ZERO);

    // Three frozen cycles with pending branch + load-use, then ack releases them.
    step("frz_run",   1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, V_FRZ);
    step("frz_w1",    1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, V_FRZ);
    step("frz_w2",    1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, V_FRZ);
    step("ack_out",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, V_BR);
    step("run_back",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_ZERO);

    // Timeout: eight frozen cycles, then sticky fault that ignores ack.
    step("to_run",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_FRZ);
    for (int i = 0; i < 7; i++)
      step("to_wait", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_FRZ);
    step("fault",     1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_FLT);
    step("fault_ack", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, V_FLT);
    step("fault_hold",1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_FLT);

    // Reset mid-cycle during FAULT: boot outputs before the next edge.
    step("rst_fault", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_BOOT);
    boot_seq();

    // Reset mid-cycle during MEM_WAIT; the following boot length proves cnt_q cleared.
    step("mw_run",    1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_FRZ);
    step("mw_wait",   1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_FRZ);
    step("rst_mw",    1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, V_BOOT);
    step("rst_hold",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_BOOT);
    boot_seq();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
